// File: rtl/pet_button_ctrl.sv
// Button front end for the pet FSM: synchronise and debounce three buttons, then turn them into
// single-cycle A/B/C command pulses (B auto-repeats, long C press requests a reset).
module pet_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 20,
    parameter int REPEAT_CYCLES   = 8,
    parameter int LONG_CYCLES     = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_a,
    input  logic btn_b,
    input  logic btn_c,
    output logic A,
    output logic B,
    output logic C,
    output logic rst_req
);
    // state     | meaning
    // C_IDLE    | C released, waiting for a debounced press
    // C_PRESSED | C held, long-press timer running; release here issues C
    // C_LONG    | long press already reported, waiting for release
    typedef enum logic [1:0] {C_IDLE, C_PRESSED, C_LONG} c_state_e;

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int LW   = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] HOLD_LOAD = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LOAD  = RW'(REPEAT_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LOAD = (LONG_CYCLES >= 2) ? LW'(LONG_CYCLES - 2) : '0;

    // bit 0 = A, bit 1 = B, bit 2 = C
    logic [2:0]    sync1_q, sync2_q, deb_q, deb_prev_q;
    logic [DW-1:0] deb_cnt_q [3];
    logic [2:0]    rise, fall;

    logic [RW-1:0] rpt_q, rpt_d;
    logic [LW-1:0] long_q, long_d;
    c_state_e      c_state_q, c_state_d;
    logic [2:0]    pend_q, pend_d;
    logic [3:0]    out_q, out_d;

    logic [2:0]    ev, req, grant;
    logic          ev_rst;

    assign rise = deb_q & ~deb_prev_q;
    assign fall = ~deb_q & deb_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= {btn_c, btn_b, btn_a};
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            // level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (deb_cnt_q[i] == DEB_LAST) begin
                        deb_q[i]     <= sync2_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        ev        = '0;
        ev_rst    = 1'b0;
        rpt_d     = rpt_q;
        long_d    = long_q;
        c_state_d = c_state_q;
        grant     = '0;
        pend_d    = pend_q;

        ev[0] = rise[0];

        if (rise[1]) begin
            ev[1] = 1'b1;
            rpt_d = HOLD_LOAD;
        end else if (deb_q[1]) begin
            if (rpt_q == '0) begin
                ev[1] = 1'b1;
                rpt_d = RPT_LOAD;
            end else begin
                rpt_d = rpt_q - 1'b1;
            end
        end else begin
            rpt_d = '0;
        end

        case (c_state_q)
            C_IDLE: begin
                if (rise[2]) begin
                    c_state_d = C_PRESSED;
                    long_d    = LONG_LOAD;
                end
            end
            C_PRESSED: begin
                if (fall[2]) begin
                    ev[2]     = 1'b1;
                    c_state_d = C_IDLE;
                end else if (long_q == '0) begin
                    ev_rst    = 1'b1;
                    c_state_d = C_LONG;
                end else begin
                    long_d = long_q - 1'b1;
                end
            end
            C_LONG: begin
                if (fall[2]) c_state_d = C_IDLE;
            end
            default: c_state_d = C_IDLE;
        endcase

        req = pend_q | ev;
        if (req[2])      grant[2] = 1'b1;
        else if (req[0]) grant[0] = 1'b1;
        else if (req[1]) grant[1] = 1'b1;

        // a served pending slot refills with a same-cycle event; otherwise extra events are lost
        for (int i = 0; i < 3; i++)
            pend_d[i] = grant[i] ? (pend_q[i] & ev[i]) : req[i];

        out_d = {ev_rst, grant[2], grant[1], grant[0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_q     <= '0;
            long_q    <= '0;
            c_state_q <= C_IDLE;
            pend_q    <= '0;
            out_q     <= '0;
        end else begin
            rpt_q     <= rpt_d;
            long_q    <= long_d;
            c_state_q <= c_state_d;
            pend_q    <= pend_d;
            out_q     <= out_d;
        end
    end

    assign A       = out_q[0];
    assign B       = out_q[1];
    assign C       = out_q[2];
    assign rst_req = out_q[3];
endmodule
